// File: rtl/demux5_distribuidor.sv
// Five-way demultiplexer: steers one source word to a destination chosen by controle,
// each destination holding one word behind a valid/ready handshake.
module demux5_distribuidor #(
  parameter int unsigned LARGURA = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] entrada,
  input  logic               entrada_valida,
  input  logic [2:0]         controle,
  output logic               entrada_pronta,
  output logic [LARGURA-1:0] saida0,
  output logic [LARGURA-1:0] saida1,
  output logic [LARGURA-1:0] saida2,
  output logic [LARGURA-1:0] saida3,
  output logic [LARGURA-1:0] saida4,
  output logic [4:0]         saida_valida,
  input  logic [4:0]         saida_pronta,
  output logic               erro,
  output logic [CNT_W-1:0]   descartes
);

  localparam int unsigned NCANAIS = 5;

  logic [LARGURA-1:0] dados [NCANAIS];
  logic [7:0]         livre;
  logic               legal;
  logic               aceita;

  // Codes 5..7 are always accepted so an illegal word can never stall the source.
  always_comb begin
    legal          = (controle < 3'(NCANAIS));
    livre          = {3'b111, (~saida_valida | saida_pronta)};
    entrada_pronta = livre[controle];
    aceita         = entrada_valida & entrada_pronta;
  end

  // Per-channel one-entry holding registers; load wins over drain on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NCANAIS; k++) dados[k] <= '0;
      saida_valida <= '0;
    end else begin
      for (int k = 0; k < NCANAIS; k++) begin
        if (aceita && legal && (controle == 3'(k))) begin
          dados[k]        <= entrada;
          saida_valida[k] <= 1'b1;
        end else if (saida_valida[k] && saida_pronta[k]) begin
          saida_valida[k] <= 1'b0;
        end
      end
    end
  end

  // Illegal-code drop reporting: one-cycle pulse plus saturating count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      erro      <= 1'b0;
      descartes <= '0;
    end else begin
      erro <= aceita & ~legal;
      if (aceita && !legal && (descartes != {CNT_W{1'b1}}))
        descartes <= descartes + CNT_W'(1);
    end
  end

  always_comb begin
    saida0 = dados[0];
    saida1 = dados[1];
    saida2 = dados[2];
    saida3 = dados[3];
    saida4 = dados[4];
  end

endmodule

// File: tb/tb_demux5_distribuidor.sv
// Bench for demux5_distribuidor: directed vector table, reset/saturation sequences,
// and a randomized run against a per-channel queue model.
module tb_demux5_distribuidor;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] entrada = '0;
  logic        entrada_valida = 1'b0;
  logic [2:0]  controle = '0;
  logic        entrada_pronta;
  logic [15:0] saida0, saida1, saida2, saida3, saida4;
  logic [4:0]  saida_valida;
  logic [4:0]  saida_pronta = '0;
  logic        erro;
  logic [7:0]  descartes;

  int checks = 0;
  int errors = 0;

  demux5_distribuidor #(.LARGURA(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .entrada(entrada), .entrada_valida(entrada_valida),
    .controle(controle), .entrada_pronta(entrada_pronta),
    .saida0(saida0), .saida1(saida1), .saida2(saida2), .saida3(saida3), .saida4(saida4),
    .saida_valida(saida_valida), .saida_pronta(saida_pronta),
    .erro(erro), .descartes(descartes)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] ent;
    logic        v;
    logic [2:0]  ctl;
    logic [4:0]  rdy;
    logic        exp_pronta;
    logic [4:0]  exp_sv;
    logic        exp_erro;
    logic [7:0]  exp_desc;
    int          chk_ch;
    logic [15:0] exp_dat;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] q[5][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] saida_de(input int k);
    case (k)
      0: return saida0;
      1: return saida1;
      2: return saida2;
      3: return saida3;
      default: return saida4;
    endcase
  endfunction

  function automatic vec_t mk(input logic [15:0] ent, input logic v, input logic [2:0] ctl,
                              input logic [4:0] rdy, input logic ep, input logic [4:0] sv,
                              input logic er, input logic [7:0] ds, input int ch,
                              input logic [15:0] dat);
    vec_t r;
    r.ent = ent; r.v = v; r.ctl = ctl; r.rdy = rdy; r.exp_pronta = ep; r.exp_sv = sv;
    r.exp_erro = er; r.exp_desc = ds; r.chk_ch = ch; r.exp_dat = dat;
    return r;
  endfunction

  task automatic drive(input logic [15:0] ent, input logic v, input logic [2:0] ctl,
                       input logic [4:0] rdy);
    entrada = ent; entrada_valida = v; controle = ctl; saida_pronta = rdy;
  endtask

  initial begin
    logic [7:0]  m_desc;
    logic        m_erro;
    logic        exp_pr;
    logic        acc;
    logic [2:0]  c;
    logic [4:0]  r;

    // ch3 fill/stall/pass-through, ch1 streaming, illegal codes, ch0 stall vs ch4 stream
    vecs.push_back(mk(16'hBEEF, 1, 3, 5'b00000, 1, 5'b01000, 0, 0, 3, 16'hBEEF));
    vecs.push_back(mk(16'h1234, 1, 3, 5'b00000, 0, 5'b01000, 0, 0, 3, 16'hBEEF));
    vecs.push_back(mk(16'h1234, 1, 3, 5'b01000, 1, 5'b01000, 0, 0, 3, 16'h1234));
    vecs.push_back(mk(16'h0000, 0, 0, 5'b01000, 1, 5'b00000, 0, 0, 3, 16'h1234));
    vecs.push_back(mk(16'h0001, 1, 1, 5'b00010, 1, 5'b00010, 0, 0, 1, 16'h0001));
    vecs.push_back(mk(16'h0002, 1, 1, 5'b00010, 1, 5'b00010, 0, 0, 1, 16'h0002));
    vecs.push_back(mk(16'h0003, 1, 1, 5'b00010, 1, 5'b00010, 0, 0, 1, 16'h0003));
    vecs.push_back(mk(16'h0004, 1, 1, 5'b00010, 1, 5'b00010, 0, 0, 1, 16'h0004));
    vecs.push_back(mk(16'h0000, 0, 1, 5'b00010, 1, 5'b00000, 0, 0, 1, 16'h0004));
    vecs.push_back(mk(16'hAAAA, 1, 6, 5'b00000, 1, 5'b00000, 1, 1, -1, 16'h0000));
    vecs.push_back(mk(16'h0000, 0, 6, 5'b00000, 1, 5'b00000, 0, 1, -1, 16'h0000));
    vecs.push_back(mk(16'h5555, 1, 0, 5'b00000, 1, 5'b00001, 0, 1, 0, 16'h5555));
    vecs.push_back(mk(16'h4001, 1, 4, 5'b00000, 1, 5'b10001, 0, 1, 4, 16'h4001));
    vecs.push_back(mk(16'h4002, 1, 4, 5'b10000, 1, 5'b10001, 0, 1, 4, 16'h4002));
    vecs.push_back(mk(16'h4003, 1, 4, 5'b10000, 1, 5'b10001, 0, 1, 0, 16'h5555));
    vecs.push_back(mk(16'h7777, 1, 0, 5'b00000, 0, 5'b10001, 0, 1, 0, 16'h5555));
    vecs.push_back(mk(16'h9999, 1, 5, 5'b00000, 1, 5'b10001, 1, 2, 4, 16'h4003));
    vecs.push_back(mk(16'h9998, 1, 7, 5'b00000, 1, 5'b10001, 1, 3, 0, 16'h5555));
    vecs.push_back(mk(16'h0000, 0, 7, 5'b00000, 1, 5'b10001, 0, 3, 4, 16'h4003));

    #2;
    chk("reset_sv", 32'(saida_valida), 0);
    chk("reset_erro", 32'(erro), 0);
    chk("reset_desc", 32'(descartes), 0);
    chk("reset_saida3", 32'(saida3), 0);
    #21 reset = 1'b1;
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].ent, vecs[i].v, vecs[i].ctl, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d_pronta", i), 32'(entrada_pronta), 32'(vecs[i].exp_pronta));
      @(posedge clock); #1;
      chk($sformatf("v%0d_sv", i), 32'(saida_valida), 32'(vecs[i].exp_sv));
      chk($sformatf("v%0d_erro", i), 32'(erro), 32'(vecs[i].exp_erro));
      chk($sformatf("v%0d_desc", i), 32'(descartes), 32'(vecs[i].exp_desc));
      if (vecs[i].chk_ch >= 0)
        chk($sformatf("v%0d_dat%0d", i, vecs[i].chk_ch), 32'(saida_de(vecs[i].chk_ch)),
            32'(vecs[i].exp_dat));
    end

    // Async reset mid-cycle with only ch2 holding a word
    drive(16'h0000, 0, 0, 5'b11111);
    @(posedge clock); #1;
    drive(16'hC2C2, 1, 2, 5'b00000);
    @(posedge clock); #1;
    drive(16'h0000, 0, 0, 5'b00000);
    chk("pre_rst_sv", 32'(saida_valida), 32'(5'b00100));
    chk("pre_rst_saida2", 32'(saida2), 32'(16'hC2C2));
    #2 reset = 1'b0;
    #1;
    chk("async_rst_sv", 32'(saida_valida), 0);
    chk("async_rst_saida2", 32'(saida2), 0);
    chk("async_rst_saida4", 32'(saida4), 0);
    chk("async_rst_desc", 32'(descartes), 0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    // 300 illegal words: counter must stick at all-ones
    drive(16'hDEAD, 1, 6, 5'b00000);
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      if (i == 0) chk("sat_first", 32'(descartes), 1);
      if (i == 254) chk("sat_255", 32'(descartes), 32'hFF);
    end
    chk("sat_final", 32'(descartes), 32'hFF);
    chk("sat_erro", 32'(erro), 1);
    chk("sat_sv", 32'(saida_valida), 0);
    drive(16'h0000, 0, 0, 5'b00000);
    @(posedge clock); #1;
    chk("sat_erro_clear", 32'(erro), 0);
    chk("sat_hold", 32'(descartes), 32'hFF);

    // Randomized traffic against a queue model
    reset = 1'b0; #1;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    m_desc = '0; m_erro = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      c = 3'($urandom_range(0, 7));
      r = 5'($urandom);
      drive(16'($urandom), ($urandom_range(0, 3) != 0), c, r);
      #1;
      exp_pr = (c >= 3'd5) ? 1'b1 : ((q[c].size() == 0) || r[c]);
      acc = entrada_valida & exp_pr;
      chk("rnd_pronta", 32'(entrada_pronta), 32'(exp_pr));
      @(posedge clock);
      for (int k = 0; k < 5; k++)
        if (q[k].size() != 0 && r[k]) void'(q[k].pop_front());
      m_erro = 1'b0;
      if (acc) begin
        if (c < 3'd5) q[c].push_back(entrada);
        else begin
          m_erro = 1'b1;
          if (m_desc != 8'hFF) m_desc = m_desc + 8'd1;
        end
      end
      #1;
      for (int k = 0; k < 5; k++) begin
        chk("rnd_valid", 32'(saida_valida[k]), 32'(q[k].size() != 0));
        if (q[k].size() > 1) chk("rnd_depth", 32'(q[k].size()), 1);
        if (q[k].size() != 0) chk($sformatf("rnd_dat%0d", k), 32'(saida_de(k)), 32'(q[k][0]));
      end
      chk("rnd_erro", 32'(erro), 32'(m_erro));
      chk("rnd_desc", 32'(descartes), 32'(m_desc));
    end

    drive(16'h0000, 0, 0, 5'b11111);
    @(posedge clock); #1;
    for (int k = 0; k < 5; k++) q[k].delete();
    chk("drain_sv", 32'(saida_valida), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
